// File: rtl/huffman_table_loader_pkg.sv
// Shared definitions for the Huffman decoder table loader.
// Holds the FSM state encoding, a log2 helper and the default table depth.
package huffman_table_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_FILL   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  localparam int MAX_CODE_LENGTH_DEFAULT = 9;
  localparam int TABLE_DEPTH = 1 << MAX_CODE_LENGTH_DEFAULT;

  function automatic int log2_ceil(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < x) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/huffman_table_loader.sv
// Programs the decoder's code-width/data tables from canonical (length, symbol)
// descriptors, replicating each entry over the left-aligned span it covers.
module huffman_table_loader
  import huffman_table_loader_pkg::*;
#(
  parameter int WIDTH_OUT            = 8,
  parameter int MAX_CODE_LENGTH      = MAX_CODE_LENGTH_DEFAULT,
  parameter int LOG2_MAX_CODE_LENGTH = log2_ceil(MAX_CODE_LENGTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            sym_valid,
  output logic                            sym_ready,
  input  logic [LOG2_MAX_CODE_LENGTH-1:0] sym_len,
  input  logic [WIDTH_OUT-1:0]            sym_data,
  input  logic                            sym_last,
  output logic                            table_push,
  output logic [MAX_CODE_LENGTH-1:0]      table_addr,
  output logic [LOG2_MAX_CODE_LENGTH-1:0] table_code_width,
  output logic [WIDTH_OUT-1:0]            table_data,
  output logic                            hold,
  output logic                            done,
  output logic                            incomplete,
  output logic                            error
);

  localparam int ML = MAX_CODE_LENGTH;
  localparam int LW = LOG2_MAX_CODE_LENGTH;
  localparam logic [ML:0]   DEPTH   = {1'b1, {ML{1'b0}}};
  localparam logic [LW-1:0] MAX_LEN = LW'(ML);

  state_t            state_r, state_n;
  logic [ML:0]       cur_r, cur_n;
  logic [LW-1:0]     len_r, len_n, prev_len_r, prev_len_n;
  logic [WIDTH_OUT-1:0] data_r, data_n;
  logic              last_r, last_n;
  logic              push_r, push_n, ready_r, ready_n;
  logic [ML-1:0]     addr_r, addr_n;
  logic [LW-1:0]     width_r, width_n;
  logic [WIDTH_OUT-1:0] tdata_r, tdata_n;
  logic              hold_r, hold_n, done_r, done_n, inc_r, inc_n, err_r, err_n;

  logic [ML+1:0]     span_s, sum_s;
  logic [ML:0]       mask_s;
  logic              bad_len_s, overflow_s, span_end_s;

  // Span of the offered descriptor, legality checks and end-of-span detection.
  always_comb begin
    span_s     = (ML+2)'(1) << (MAX_LEN - sym_len);
    sum_s      = {1'b0, cur_r} + span_s;
    bad_len_s  = (sym_len == {LW{1'b0}}) || (sym_len > MAX_LEN) || (sym_len < prev_len_r);
    overflow_s = sum_s > {1'b0, DEPTH};
    // Canonical codes start span-aligned, so a span ends when cur realigns.
    mask_s     = ((ML+1)'(1) << (MAX_LEN - len_r)) - (ML+1)'(1);
    span_end_s = (cur_r & mask_s) == {(ML+1){1'b0}};
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n    = state_r;
    cur_n      = cur_r;
    len_n      = len_r;
    data_n     = data_r;
    last_n     = last_r;
    prev_len_n = prev_len_r;
    push_n     = 1'b0;
    ready_n    = 1'b0;
    addr_n     = addr_r;
    width_n    = width_r;
    tdata_n    = tdata_r;
    hold_n     = hold_r;
    done_n     = done_r;
    inc_n      = inc_r;
    err_n      = err_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_n    = ST_ACCEPT;
          cur_n      = {(ML+1){1'b0}};
          prev_len_n = LW'(1);
          done_n     = 1'b0;
          inc_n      = 1'b0;
          err_n      = 1'b0;
          hold_n     = 1'b1;
          ready_n    = 1'b1;
        end else if (state_r == ST_DONE) begin
          hold_n = 1'b0;
        end else begin
          hold_n = hold_r;
        end
      end
      ST_ACCEPT: begin
        ready_n = 1'b1;
        if (sym_valid) begin
          ready_n = 1'b0;
          if (bad_len_s || overflow_s) begin
            state_n = ST_ERROR;
            err_n   = 1'b1;
          end else begin
            state_n    = ST_WRITE;
            len_n      = sym_len;
            data_n     = sym_data;
            last_n     = sym_last;
            prev_len_n = sym_len;
            push_n     = 1'b1;
            addr_n     = cur_r[ML-1:0];
            width_n    = sym_len;
            tdata_n    = sym_data;
            cur_n      = cur_r + (ML+1)'(1);
          end
        end else begin
          state_n = ST_ACCEPT;
        end
      end
      ST_WRITE: begin
        if (!span_end_s) begin
          push_n  = 1'b1;
          addr_n  = cur_r[ML-1:0];
          width_n = len_r;
          tdata_n = data_r;
          cur_n   = cur_r + (ML+1)'(1);
        end else if (!last_r) begin
          state_n = ST_ACCEPT;
          ready_n = 1'b1;
        end else if (cur_r == DEPTH) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end else begin
          state_n = ST_FILL;
          push_n  = 1'b1;
          addr_n  = cur_r[ML-1:0];
          width_n = {LW{1'b0}};
          tdata_n = {WIDTH_OUT{1'b0}};
          cur_n   = cur_r + (ML+1)'(1);
        end
      end
      ST_FILL: begin
        if (cur_r == DEPTH) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
          inc_n   = 1'b1;
        end else begin
          push_n  = 1'b1;
          addr_n  = cur_r[ML-1:0];
          width_n = {LW{1'b0}};
          tdata_n = {WIDTH_OUT{1'b0}};
          cur_n   = cur_r + (ML+1)'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cur_r      <= {(ML+1){1'b0}};
      len_r      <= {LW{1'b0}};
      data_r     <= {WIDTH_OUT{1'b0}};
      last_r     <= 1'b0;
      prev_len_r <= LW'(1);
      push_r     <= 1'b0;
      ready_r    <= 1'b0;
      addr_r     <= {ML{1'b0}};
      width_r    <= {LW{1'b0}};
      tdata_r    <= {WIDTH_OUT{1'b0}};
      hold_r     <= 1'b0;
      done_r     <= 1'b0;
      inc_r      <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_n;
      cur_r      <= cur_n;
      len_r      <= len_n;
      data_r     <= data_n;
      last_r     <= last_n;
      prev_len_r <= prev_len_n;
      push_r     <= push_n;
      ready_r    <= ready_n;
      addr_r     <= addr_n;
      width_r    <= width_n;
      tdata_r    <= tdata_n;
      hold_r     <= hold_n;
      done_r     <= done_n;
      inc_r      <= inc_n;
      err_r      <= err_n;
    end
  end

  assign sym_ready        = ready_r;
  assign table_push       = push_r;
  assign table_addr       = addr_r;
  assign table_code_width = width_r;
  assign table_data       = tdata_r;
  assign hold             = hold_r;
  assign done             = done_r;
  assign incomplete       = inc_r;
  assign error            = err_r;

endmodule

// File: tb/tb_huffman_table_loader.sv
// Directed bench for huffman_table_loader with MAX_CODE_LENGTH=3; expected
// table writes are queued as descriptors are sent and checked as pushes appear.
module tb_huffman_table_loader;

  logic       clk = 1'b0;
  logic       rst, start, sym_valid, sym_last;
  logic [2:0] sym_len;
  logic [7:0] sym_data;
  logic       sym_ready, table_push, hold, done, incomplete, error;
  logic [2:0] table_addr, table_code_width;
  logic [7:0] table_data;

  huffman_table_loader #(
    .WIDTH_OUT(8), .MAX_CODE_LENGTH(3), .LOG2_MAX_CODE_LENGTH(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .sym_len(sym_len), .sym_data(sym_data),
    .sym_last(sym_last), .table_push(table_push), .table_addr(table_addr),
    .table_code_width(table_code_width), .table_data(table_data),
    .hold(hold), .done(done), .incomplete(incomplete), .error(error)
  );

  always #5 clk = ~clk;

  logic [13:0] exp_q[$];
  int n_assert = 0;
  int n_fail = 0;
  int n_push = 0;
  int cyc = 0;
  int last_push_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every observed push must match the oldest expected entry.
  always @(negedge clk) begin
    if (table_push) begin
      logic [13:0] got, e;
      n_push++;
      last_push_cyc = cyc;
      got = {table_addr, table_code_width, table_data};
      n_assert++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_push observed=%h expected=none", got);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_assert++;
        assert (got === e) else begin
          n_fail++;
          $error("FAIL push_entry observed=%h expected=%h", got, e);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_run(input int a0, input int n, input int w, input int d);
    for (int i = 0; i < n; i++) begin
      logic [2:0] a;
      logic [2:0] wv;
      logic [7:0] dv;
      a  = 3'(a0 + i);
      wv = 3'(w);
      dv = 8'(d);
      exp_q.push_back({a, wv, dv});
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int len, input int data, input logic last, output int hs_cyc);
    int k;
    sym_len   = 3'(len);
    sym_data  = 8'(data);
    sym_last  = last;
    sym_valid = 1'b1;
    for (k = 0; k < 40 && !sym_ready; k++) @(negedge clk);
    check("sym_ready_wait", {31'd0, sym_ready}, 32'd1);
    hs_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  task automatic wait_end();
    int k;
    for (k = 0; k < 100 && !(done || error); k++) @(negedge clk);
    check("end_wait", {31'd0, (done || error)}, 32'd1);
  endtask

  task automatic run_complete();
    int h0, h, p0;
    p0 = n_push;
    do_start();
    check("hold_after_start", {31'd0, hold}, 32'd1);
    expect_run(0, 4, 1, 8'h41);
    expect_run(4, 2, 2, 8'h42);
    expect_run(6, 1, 3, 8'h43);
    expect_run(7, 1, 3, 8'h44);
    send(1, 8'h41, 1'b0, h0);
    send(2, 8'h42, 1'b0, h);
    send(3, 8'h43, 1'b0, h);
    send(3, 8'h44, 1'b1, h);
    wait_end();
    check("full_done", {31'd0, done}, 32'd1);
    check("full_incomplete", {31'd0, incomplete}, 32'd0);
    check("full_error", {31'd0, error}, 32'd0);
    check("full_hold_lags_done", {31'd0, hold}, 32'd1);
    check("full_push_count", 32'(n_push - p0), 32'd8);
    check("full_latency", 32'(last_push_cyc - h0), 32'd11);
    check("full_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("full_hold_released", {31'd0, hold}, 32'd0);
    check("full_done_level", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int h, p0;
    rst = 1'b1; start = 1'b0; sym_valid = 1'b0; sym_last = 1'b0;
    sym_len = 3'd0; sym_data = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_push", {31'd0, table_push}, 32'd0);
    check("rst_hold", {31'd0, hold}, 32'd0);
    check("rst_flags", {29'd0, done, incomplete, error}, 32'd0);
    check("rst_ready", {31'd0, sym_ready}, 32'd0);
    rst = 1'b0;

    // complete code A/1 B/2 C/3 D/3
    run_complete();

    // single symbol, fill with width 0; a start pulse during FILL is ignored
    p0 = n_push;
    do_start();
    expect_run(0, 4, 1, 8'h41);
    expect_run(4, 4, 0, 0);
    send(1, 8'h41, 1'b1, h);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end();
    check("single_done", {31'd0, done}, 32'd1);
    check("single_incomplete", {31'd0, incomplete}, 32'd1);
    check("single_push_count", 32'(n_push - p0), 32'd8);

    // overflow: third length-1 code does not fit
    p0 = n_push;
    do_start();
    expect_run(0, 4, 1, 8'h41);
    expect_run(4, 4, 1, 8'h42);
    send(1, 8'h41, 1'b0, h);
    send(1, 8'h42, 1'b0, h);
    send(1, 8'h43, 1'b0, h);
    check("ovf_error", {31'd0, error}, 32'd1);
    check("ovf_hold", {31'd0, hold}, 32'd1);
    check("ovf_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("ovf_no_push", {31'd0, table_push}, 32'd0);
    check("ovf_push_count", 32'(n_push - p0), 32'd8);

    // decreasing length
    p0 = n_push;
    do_start();
    expect_run(0, 2, 2, 8'h41);
    send(2, 8'h41, 1'b0, h);
    send(1, 8'h42, 1'b1, h);
    check("dec_error", {31'd0, error}, 32'd1);
    @(negedge clk);
    check("dec_push_count", 32'(n_push - p0), 32'd2);

    // illegal lengths 0 and 4
    p0 = n_push;
    do_start();
    send(0, 8'h41, 1'b1, h);
    check("len0_error", {31'd0, error}, 32'd1);
    do_start();
    check("restart_clears_error", {31'd0, error}, 32'd0);
    send(4, 8'h41, 1'b1, h);
    check("len4_error", {31'd0, error}, 32'd1);
    @(negedge clk);
    check("badlen_push_count", 32'(n_push - p0), 32'd0);

    // reset in the middle of WRITE
    p0 = n_push;
    do_start();
    expect_run(0, 4, 1, 8'h41);
    send(1, 8'h41, 1'b0, h);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_push", {31'd0, table_push}, 32'd0);
    check("midrst_hold", {31'd0, hold}, 32'd0);
    check("midrst_ready", {31'd0, sym_ready}, 32'd0);
    check("midrst_push_count", 32'(n_push - p0), 32'd2);
    rst = 1'b0;
    exp_q.delete();
    run_complete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
